// File: rtl/sync_decoder_pkg.sv
// Shared types and constants for the sync-code frame/line decoder.
package sync_decoder_pkg;

  localparam int CNT_W = 16;

  localparam logic [11:0] CODE_FS_DEF = 12'hFF0;
  localparam logic [11:0] CODE_FE_DEF = 12'hFF1;
  localparam logic [11:0] CODE_LS_DEF = 12'hFF2;
  localparam logic [11:0] CODE_LE_DEF = 12'hFF3;

  typedef enum logic [1:0] {
    s_IDLE    = 2'd0,
    s_WAIT_FS = 2'd1,
    s_FRAME   = 2'd2,
    s_LINE    = 2'd3
  } state_t;

  // One-hot after priority resolution: fs > fe > ls > le.
  typedef struct packed {
    logic fs;
    logic fe;
    logic ls;
    logic le;
  } code_flags_t;

endpackage

// File: rtl/sync_code_match.sv
// Stage 1: register the parallel bus and flag which sync code the sync channel carries.
module sync_code_match
  import sync_decoder_pkg::*;
#(
  parameter int NCH     = 32,
  parameter int W       = 12,
  parameter int SYNC_CH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] data,
  input  logic [W-1:0]     code_fs,
  input  logic [W-1:0]     code_fe,
  input  logic [W-1:0]     code_ls,
  input  logic [W-1:0]     code_le,
  output logic [NCH*W-1:0] data_q,
  output code_flags_t      flags
);

  logic [W-1:0] sync_word;
  code_flags_t  flags_d;

  assign sync_word = data[SYNC_CH*W +: W];

  // Priority chain keeps the flags one-hot if registers hold equal codes.
  always_comb begin
    flags_d = '0;
    if      (sync_word == code_fs) flags_d.fs = 1'b1;
    else if (sync_word == code_fe) flags_d.fe = 1'b1;
    else if (sync_word == code_ls) flags_d.ls = 1'b1;
    else if (sync_word == code_le) flags_d.le = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      flags  <= '0;
    end else begin
      data_q <= data;
      flags  <= flags_d;
    end
  end

endmodule

// File: rtl/sync_decoder.sv
// Frame/line timing decoder: embedded sync codes -> fval/lval/dval, counts and sticky error.
module sync_decoder
  import sync_decoder_pkg::*;
#(
  parameter int NCH     = 32,
  parameter int W       = 12,
  parameter int SYNC_CH = 0
) (
  input  logic             clk_rxg,
  input  logic             rst_rx_n,
  input  logic             training_done,
  input  logic [W-1:0]     code_fs,
  input  logic [W-1:0]     code_fe,
  input  logic [W-1:0]     code_ls,
  input  logic [W-1:0]     code_le,
  input  logic [NCH*W-1:0] data_par_trained,
  input  logic             err_clr,
  output logic             fval,
  output logic             lval,
  output logic             dval,
  output logic [NCH*W-1:0] data_out,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             err_sync
);

  logic [NCH*W-1:0] data_q;
  code_flags_t      flags;
  logic             any_code;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lines_run, pix_run;
  logic             err_set, clr_lines, inc_line, clr_pix, inc_pix;
  logic             latch_lines, latch_pix;
  logic             fval_d, lval_d;

  sync_code_match #(.NCH(NCH), .W(W), .SYNC_CH(SYNC_CH)) u_match (
    .clk     (clk_rxg),
    .rst_n   (rst_rx_n),
    .data    (data_par_trained),
    .code_fs (code_fs),
    .code_fe (code_fe),
    .code_ls (code_ls),
    .code_le (code_le),
    .data_q  (data_q),
    .flags   (flags)
  );

  assign any_code = |flags;

  always_comb begin
    state_nxt   = state;
    err_set     = 1'b0;
    clr_lines   = 1'b0;
    inc_line    = 1'b0;
    clr_pix     = 1'b0;
    inc_pix     = 1'b0;
    latch_lines = 1'b0;
    latch_pix   = 1'b0;
    if (!training_done) begin
      state_nxt = s_IDLE;
    end else begin
      unique case (state)
        s_IDLE: state_nxt = s_WAIT_FS;
        s_WAIT_FS: begin
          if (flags.fs) begin
            state_nxt = s_FRAME;
            clr_lines = 1'b1;
          end
        end
        s_FRAME: begin
          if (flags.fs) begin
            err_set   = 1'b1;
            clr_lines = 1'b1;
          end else if (flags.fe) begin
            state_nxt   = s_WAIT_FS;
            latch_lines = 1'b1;
          end else if (flags.ls) begin
            state_nxt = s_LINE;
            clr_pix   = 1'b1;
          end else if (flags.le) begin
            err_set = 1'b1;
          end
        end
        s_LINE: begin
          if (flags.fs) begin
            err_set   = 1'b1;
            state_nxt = s_FRAME;
            clr_lines = 1'b1;
          end else if (flags.fe) begin
            err_set   = 1'b1;
            state_nxt = s_WAIT_FS;
          end else if (flags.ls) begin
            err_set = 1'b1;
            clr_pix = 1'b1;
          end else if (flags.le) begin
            state_nxt = s_FRAME;
            latch_pix = 1'b1;
            inc_line  = 1'b1;
          end else begin
            inc_pix = 1'b1;
          end
        end
        default: state_nxt = s_IDLE;
      endcase
    end
  end

  // Valids follow the current state, so a training_done drop clears them one cycle after the FSM idles.
  assign fval_d = (state == s_FRAME) || (state == s_LINE) ||
                  ((state == s_WAIT_FS) && training_done && flags.fs);
  assign lval_d = (state == s_LINE) && !any_code;

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state     <= s_IDLE;
      data_out  <= '0;
      fval      <= 1'b0;
      lval      <= 1'b0;
      dval      <= 1'b0;
      lines_run <= '0;
      pix_run   <= '0;
      line_cnt  <= '0;
      pix_cnt   <= '0;
      err_sync  <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= data_q;
      fval     <= fval_d;
      lval     <= lval_d;
      dval     <= lval_d;
      if (clr_lines)     lines_run <= '0;
      else if (inc_line) lines_run <= lines_run + CNT_W'(1);
      if (clr_pix)                       pix_run <= '0;
      else if (inc_pix && pix_run != '1) pix_run <= pix_run + CNT_W'(1);
      if (latch_lines) line_cnt <= lines_run;
      if (latch_pix)   pix_cnt  <= pix_run;
      if (err_set)      err_sync <= 1'b1;
      else if (err_clr) err_sync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench for sync_decoder: words change on negedge, outputs sampled on negedge.
module tb_sync_decoder;
  import sync_decoder_pkg::*;

  localparam int NCH = 32;
  localparam int W   = 12;

  logic             clk_rxg = 1'b0;
  logic             rst_rx_n = 1'b0;
  logic             training_done = 1'b0;
  logic [W-1:0]     code_fs = CODE_FS_DEF;
  logic [W-1:0]     code_fe = CODE_FE_DEF;
  logic [W-1:0]     code_ls = CODE_LS_DEF;
  logic [W-1:0]     code_le = CODE_LE_DEF;
  logic [NCH*W-1:0] data_par_trained = '0;
  logic             err_clr = 1'b0;
  logic             fval, lval, dval, err_sync;
  logic [NCH*W-1:0] data_out;
  logic [15:0]      line_cnt, pix_cnt;

  int checks = 0;
  int errors = 0;
  int fv_n = 0, lv_n = 0, dv_n = 0;

  sync_decoder #(.NCH(NCH), .W(W), .SYNC_CH(0)) dut (
    .clk_rxg          (clk_rxg),
    .rst_rx_n         (rst_rx_n),
    .training_done    (training_done),
    .code_fs          (code_fs),
    .code_fe          (code_fe),
    .code_ls          (code_ls),
    .code_le          (code_le),
    .data_par_trained (data_par_trained),
    .err_clr          (err_clr),
    .fval             (fval),
    .lval             (lval),
    .dval             (dval),
    .data_out         (data_out),
    .line_cnt         (line_cnt),
    .pix_cnt          (pix_cnt),
    .err_sync         (err_sync)
  );

  always #5 clk_rxg = ~clk_rxg;

  function automatic logic [NCH*W-1:0] fill(input logic [W-1:0] w);
    return {NCH{w}};
  endfunction

  function automatic logic [W-1:0] pixw(input int p);
    return W'(p % 1000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // After push(w) returns, the outputs reflect the word pushed just before w.
  task automatic push(input logic [W-1:0] w);
    data_par_trained = fill(w);
    @(negedge clk_rxg);
    fv_n += int'(fval);
    lv_n += int'(lval);
    dv_n += int'(dval);
  endtask

  task automatic send_line(input int n);
    push(code_ls);
    for (int p = 0; p < n; p++) push(pixw(p));
    push(code_le);
  endtask

  task automatic clr_acc();
    fv_n = 0; lv_n = 0; dv_n = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk_rxg);
    chk("rst_fval", 32'(fval), 0);
    chk("rst_lval", 32'(lval), 0);
    chk("rst_dval", 32'(dval), 0);
    chk("rst_err", 32'(err_sync), 0);
    chk("rst_line_cnt", 32'(line_cnt), 0);
    chk("rst_pix_cnt", 32'(pix_cnt), 0);
    chk_bus("rst_data_out", data_out, '0);
    rst_rx_n = 1'b1;
    training_done = 1'b1;
    repeat (3) push(pixw(7));

    // Nominal frame: FS, 3 x (LS, 100 px, LE), FE
    clr_acc();
    push(code_fs);
    chk("nom_pre_fs_fval", 32'(fval), 0);
    for (int l = 0; l < 3; l++) begin
      push(code_ls);
      if (l == 0) begin
        chk("nom_fs_fval", 32'(fval), 1);
        chk("nom_fs_dval", 32'(dval), 0);
        chk_bus("nom_fs_data", data_out, fill(code_fs));
      end
      for (int p = 0; p < 100; p++) begin
        push(pixw(p));
        if (l == 0 && p == 0) chk("nom_ls_lval", 32'(lval), 0);
        if (l == 0 && p == 1) begin
          chk("nom_px0_lval", 32'(lval), 1);
          chk("nom_px0_dval", 32'(dval), 1);
          chk_bus("nom_px0_data", data_out, fill(pixw(0)));
        end
      end
      push(code_le);
    end
    push(code_fe);
    repeat (2) push(pixw(3));
    // FS word + 306 line words + FE word all carry fval
    chk("nom_fval_cycles", 32'(fv_n), 308);
    chk("nom_lval_cycles", 32'(lv_n), 300);
    chk("nom_dval_cycles", 32'(dv_n), 300);
    chk("nom_pix_cnt", 32'(pix_cnt), 100);
    chk("nom_line_cnt", 32'(line_cnt), 3);
    chk("nom_err", 32'(err_sync), 0);

    // LE while in s_FRAME flags an error but keeps the frame
    push(code_fs);
    push(code_le);
    push(pixw(1));
    chk("le_frame_err", 32'(err_sync), 1);
    chk("le_frame_fval", 32'(fval), 1);
    send_line(5);
    push(pixw(2));
    chk("le_frame_pix_cnt", 32'(pix_cnt), 5);
    err_clr = 1'b1;
    push(pixw(4));
    err_clr = 1'b0;
    chk("err_clr", 32'(err_sync), 0);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("le_frame_line_cnt", 32'(line_cnt), 1);
    chk("le_frame_err_after", 32'(err_sync), 0);

    // training_done low through a frame, then raised mid-frame
    clr_acc();
    training_done = 1'b0;
    push(code_fs);
    send_line(5);
    training_done = 1'b1;
    send_line(3);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("td_fval_cycles", 32'(fv_n), 0);
    chk("td_lval_cycles", 32'(lv_n), 0);
    chk("td_dval_cycles", 32'(dv_n), 0);
    chk("td_err", 32'(err_sync), 0);
    chk("td_pix_hold", 32'(pix_cnt), 5);
    clr_acc();
    push(code_fs);
    send_line(7);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("td_resume_fval_cycles", 32'(fv_n), 11);
    chk("td_resume_pix_cnt", 32'(pix_cnt), 7);
    chk("td_resume_line_cnt", 32'(line_cnt), 1);

    // Pixel counter saturation
    push(code_fs);
    send_line(70000);
    push(pixw(1));
    chk("ovf_pix_cnt", 32'(pix_cnt), 32'hFFFF);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("ovf_line_cnt", 32'(line_cnt), 1);

    // Empty line, back-to-back LE/LS, then another empty line
    clr_acc();
    push(code_fs);
    push(code_ls);
    push(code_le);
    push(code_ls);
    chk("empty_pix_cnt", 32'(pix_cnt), 0);
    for (int p = 0; p < 3; p++) push(pixw(p));
    push(code_le);
    push(code_ls);
    push(code_le);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("b2b_lval_cycles", 32'(lv_n), 3);
    chk("b2b_dval_cycles", 32'(dv_n), 3);
    chk("b2b_pix_cnt", 32'(pix_cnt), 0);
    chk("b2b_line_cnt", 32'(line_cnt), 3);
    chk("b2b_err", 32'(err_sync), 0);

    // Async reset mid-line
    push(code_fs);
    push(code_ls);
    for (int p = 0; p < 5; p++) push(pixw(p));
    #2 rst_rx_n = 1'b0;
    #1;
    chk("arst_fval", 32'(fval), 0);
    chk("arst_lval", 32'(lval), 0);
    chk("arst_dval", 32'(dval), 0);
    chk("arst_line_cnt", 32'(line_cnt), 0);
    chk("arst_pix_cnt", 32'(pix_cnt), 0);
    chk_bus("arst_data_out", data_out, '0);
    @(negedge clk_rxg);
    rst_rx_n = 1'b1;
    clr_acc();
    for (int p = 0; p < 4; p++) push(pixw(p));
    push(code_le);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("arst_skip_fval_cycles", 32'(fv_n), 0);
    chk("arst_skip_err", 32'(err_sync), 0);
    clr_acc();
    push(code_fs);
    send_line(4);
    push(code_fe);
    repeat (2) push(pixw(3));
    chk("arst_rec_lval_cycles", 32'(lv_n), 4);
    chk("arst_rec_pix_cnt", 32'(pix_cnt), 4);
    chk("arst_rec_line_cnt", 32'(line_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
